// File: rtl/add_packet_sequencer_if.sv
// Byte stream handshake between the UART rx/tx ports and the sequencer.
// master = UART/host side, slave = sequencer side.
interface add_packet_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/add_packet_sequencer.sv
// Request parser / response serializer for the four 64-bit adders.
// Optional macro RX_TIMEOUT_EN aborts a stalled request after TIMEOUT_CYCLES.
module add_packet_sequencer #(
  parameter int ADD_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_l,
  input  logic        btn_u,
  input  logic        btn_r,
  input  logic        btn_d,
  add_packet_sequencer_if.slave bus,
  output logic [63:0] op_a,
  output logic [63:0] op_b,
  output logic        op_valid,
  input  logic [63:0] res0,
  input  logic [63:0] res1,
  input  logic [63:0] res2,
  input  logic [63:0] res3,
  output logic [1:0]  sel,
  output logic        busy,
  output logic        err_pulse,
  output logic [7:0]  err_cnt,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_OPA,
    S_OPB,
    S_CSUM,
    S_WAIT,
    S_SEND
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [63:0] sha;
  logic [63:0] shb;
  logic [3:0]  idx;
  logic [3:0]  lat_cnt;
  logic [87:0] frame;
  logic [63:0] res_sel;
  logic [7:0]  ck_exp;
  logic [7:0]  ck2;
  logic        ck_ok;
  logic        ck_bad;
  logic        capture;
  logic        tmo;
  logic        rx_v;
  logic [7:0]  rx_d;
  logic        parsing;

  assign rx_v    = bus.rx_valid;
  assign rx_d    = bus.rx_data;
  assign busy    = (state == S_WAIT) || (state == S_SEND);
  assign parsing = (state == S_HDR1) || (state == S_OPA)
                || (state == S_OPB)  || (state == S_CSUM);

  // frame shifts out LSB first and refills with zeros
  assign bus.tx_data  = frame[7:0];
  assign bus.tx_valid = (state == S_SEND);

  always_comb begin
    res_sel = res0;
    unique case (sel)
      2'd0: res_sel = res0;
      2'd1: res_sel = res1;
      2'd2: res_sel = res2;
      2'd3: res_sel = res3;
    endcase
  end

  assign ck2 = 8'hFD + res_sel[7:0];

`ifdef RX_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (!parsing || rx_v)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign tmo = parsing && !rx_v
            && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state;
    ck_ok   = 1'b0;
    ck_bad  = 1'b0;
    capture = 1'b0;
    ck_exp  = 8'hCD + sha[7:0] + shb[7:0];
    unique case (state)
      S_IDLE:
        if (rx_v && rx_d == 8'hCD)
          state_d = S_HDR1;
      S_HDR1:
        if (rx_v) begin
          if (rx_d == 8'hBA)
            state_d = S_OPA;
          else if (rx_d != 8'hCD)
            state_d = S_IDLE;
        end
      S_OPA:
        if (rx_v && idx == 4'd7)
          state_d = S_OPB;
      S_OPB:
        if (rx_v && idx == 4'd7)
          state_d = S_CSUM;
      S_CSUM:
        if (rx_v) begin
          if (rx_d == ck_exp) begin
            ck_ok   = 1'b1;
            state_d = S_WAIT;
          end else begin
            ck_bad  = 1'b1;
            state_d = S_IDLE;
          end
        end
      S_WAIT:
        if (lat_cnt == 4'd0) begin
          capture = 1'b1;
          state_d = S_SEND;
        end
      S_SEND:
        if (bus.tx_ready && idx == 4'd10)
          state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    if (tmo)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sha       <= '0;
      shb       <= '0;
      idx       <= '0;
      lat_cnt   <= '0;
      frame     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_valid  <= 1'b0;
      sel       <= 2'd0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      op_valid  <= 1'b0;
      err_pulse <= 1'b0;

      if (btn_l)      sel <= 2'd0;
      else if (btn_u) sel <= 2'd1;
      else if (btn_r) sel <= 2'd2;
      else if (btn_d) sel <= 2'd3;

      if (rx_v && busy && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      if (state == S_IDLE || state == S_HDR1)
        idx <= '0;

      if (state == S_OPA && rx_v) begin
        sha <= {rx_d, sha[63:8]};
        idx <= (idx == 4'd7) ? 4'd0 : idx + 4'd1;
      end

      if (state == S_OPB && rx_v) begin
        shb <= {rx_d, shb[63:8]};
        idx <= (idx == 4'd7) ? 4'd0 : idx + 4'd1;
      end

      if (ck_ok) begin
        op_a     <= sha;
        op_b     <= shb;
        op_valid <= 1'b1;
        lat_cnt  <= 4'(ADD_LATENCY);
      end

      if ((ck_bad || tmo) && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (ck_bad || tmo)
        err_pulse <= 1'b1;

      if (state == S_WAIT && lat_cnt != 4'd0)
        lat_cnt <= lat_cnt - 4'd1;

      if (capture) begin
        frame <= {ck2, res_sel, 8'hBA, 8'hFD};
        idx   <= '0;
      end

      if (state == S_SEND && bus.tx_ready) begin
        frame <= {8'h00, frame[87:8]};
        idx   <= idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_add_packet_sequencer.sv
// Scoreboard bench: stimulus pushes expected tx bytes,
// a negedge monitor pops and compares on each tx handshake.
module tb_add_packet_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_l = 1'b0;
  logic        btn_u = 1'b0;
  logic        btn_r = 1'b0;
  logic        btn_d = 1'b0;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        op_valid;
  logic [63:0] res0;
  logic [63:0] res1;
  logic [63:0] res2;
  logic [63:0] res3;
  logic [1:0]  sel;
  logic        busy;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic [7:0]  drop_cnt;

  add_packet_sequencer_if bus ();

  always #5 clk = ~clk;

  add_packet_sequencer #(
    .ADD_LATENCY   (1),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_l    (btn_l),
    .btn_u    (btn_u),
    .btn_r    (btn_r),
    .btn_d    (btn_d),
    .bus      (bus),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .res0     (res0),
    .res1     (res1),
    .res2     (res2),
    .res3     (res3),
    .sel      (sel),
    .busy     (busy),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .drop_cnt (drop_cnt)
  );

  // stand-in adders
  assign res0 = op_a + op_b;
  assign res1 = op_a ^ op_b;
  assign res2 = op_a - op_b;
  assign res3 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int opv_cnt = 0;
  int errp_cnt = 0;
  int txv_seen = 0;
  logic stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (op_valid)     opv_cnt++;
        if (err_pulse)    errp_cnt++;
        if (bus.tx_valid) txv_seen++;
        if (stall_prev) begin
          chk("hold_valid", bus.tx_valid, 1);
          chk("hold_data", bus.tx_data, data_prev);
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx: got %0h, none expected",
                     bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", bus.tx_data, e);
          end
          acc_cnt++;
        end
        stall_prev = bus.tx_valid && !bus.tx_ready;
        data_prev  = bus.tx_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] req_ck(input logic [63:0] a,
                                        input logic [63:0] b);
    return 8'hCD + a[7:0] + b[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // send bytes [first, last) of the 19-byte request
  task automatic send_part(input logic [63:0] a,
                           input logic [63:0] b,
                           input logic [7:0]  ck,
                           input int first,
                           input int last);
    logic [7:0] pkt[19];
    pkt[0] = 8'hCD;
    pkt[1] = 8'hBA;
    for (int i = 0; i < 8; i++) begin
      pkt[2 + i]  = a[8*i +: 8];
      pkt[10 + i] = b[8*i +: 8];
    end
    pkt[18] = ck;
    for (int i = first; i < last; i++)
      send_byte(pkt[i]);
  endtask

  task automatic send_req(input logic [63:0] a,
                          input logic [63:0] b,
                          input logic [7:0]  ck);
    send_part(a, b, ck, 0, 19);
  endtask

  task automatic push_resp(input logic [63:0] r);
    exp_q.push_back(8'hFD);
    exp_q.push_back(8'hBA);
    for (int i = 0; i < 8; i++)
      exp_q.push_back(r[8*i +: 8]);
    exp_q.push_back(8'hFD + r[7:0]);
  endtask

  task automatic push_bytes(input logic [87:0] v);
    for (int i = 0; i < 11; i++)
      exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, (exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic wait_acc(input string name, input int target);
    int n = 0;
    while (acc_cnt < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, acc_cnt, target);
  endtask

  initial begin
    int base;
    int b_err;
    int b_txv;
    logic [63:0] a;
    logic [63:0] b;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // good request, 12 + 13 = 25
    btn_l = 1'b1;
    base = opv_cnt;
    push_bytes({8'h16, 56'h0, 8'h19, 8'hBA, 8'hFD});
    send_req(64'd12, 64'd13, 8'hE6);
    chk("t1_op_valid_T1", op_valid, 1);
    chk("t1_op_a", op_a, 64'd12);
    chk("t1_op_b", op_b, 64'd13);
    @(posedge clk);
    #1;
    chk("t1_op_valid_T2", op_valid, 0);
    chk("t1_tx_valid_T2", bus.tx_valid, 0);
    chk("t1_busy_T2", busy, 1);
    @(posedge clk);
    #1;
    chk("t1_tx_valid_T3", bus.tx_valid, 1);
    chk("t1_tx_first", bus.tx_data, 8'hFD);
    wait_done("t1_done");
    chk("t1_opv_pulses", opv_cnt - base, 1);
    chk("t1_err_cnt", err_cnt, 0);

    // bad checksum, then a good packet
    base  = opv_cnt;
    b_err = errp_cnt;
    b_txv = txv_seen;
    send_req(64'd12, 64'd13, 8'hE7);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_err_pulses", errp_cnt - b_err, 1);
    chk("t2_no_op_valid", opv_cnt - base, 0);
    chk("t2_no_tx", txv_seen - b_txv, 0);
    chk("t2_busy", busy, 0);
    push_bytes({8'h16, 64'h1213_1415_1617_1819,
                8'hBA, 8'hFD});
    send_req(64'h0102_0304_0506_0708,
             64'h1111_1111_1111_1111, 8'hE6);
    wait_done("t2_done");
    chk("t2_op_a", op_a, 64'h0102_0304_0506_0708);
    chk("t2_opv_pulses", opv_cnt - base, 1);

    // resync on repeated header byte, adder 1
    btn_l = 1'b0;
    btn_u = 1'b1;
    base = opv_cnt;
    a = 64'hF0F0_F0F0_F0F0_F0F0;
    b = 64'h0FF0_0FF0_0FF0_0FF0;
    push_resp(a ^ b);
    send_byte(8'hCD);
    send_req(a, b, req_ck(a, b));
    wait_done("t3_resync_done");
    chk("t3_sel_u", sel, 1);

    // aborted header then valid packet, adder 2
    btn_u = 1'b0;
    btn_r = 1'b1;
    a = 64'h0000_0001_0000_0000;
    b = 64'h0000_0000_0000_0003;
    push_resp(a - b);
    send_byte(8'hCD);
    send_byte(8'h55);
    send_req(a, b, req_ck(a, b));
    wait_done("t3_abort_done");
    chk("t3_sel_r", sel, 2);
    chk("t3_opv_pulses", opv_cnt - base, 2);

    // backpressure at byte 3, adder 3 all ones
    btn_r = 1'b0;
    btn_d = 1'b1;
    push_bytes({8'hFC, 64'hFFFF_FFFF_FFFF_FFFF,
                8'hBA, 8'hFD});
    base = acc_cnt;
    send_req(64'd5, 64'd6, req_ck(64'd5, 64'd6));
    wait_acc("t4_reach_byte3", base + 3);
    bus.tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_stall_valid", bus.tx_valid, 1);
    chk("t4_stall_data", bus.tx_data, 8'hFF);
    bus.tx_ready = 1'b1;
    wait_done("t4_done");
    chk("t4_acc_total", acc_cnt - base, 11);

    // bytes during WAIT/SEND are dropped
    btn_d = 1'b0;
    btn_l = 1'b1;
    base = drop_cnt;
    a = 64'h0000_0000_0000_0100;
    b = 64'h0000_0000_0000_0023;
    push_resp(a + b);
    send_req(a, b, req_ck(a, b));
    send_byte(8'hCD);
    send_byte(8'hBA);
    send_byte(8'h77);
    wait_done("t5_drop_done");
    chk("t5_drop_cnt", drop_cnt, base + 3);

    // reset during byte 5 of SEND
    push_resp(a + b);
    base = acc_cnt;
    send_req(a, b, req_ck(a, b));
    wait_acc("t5_reach_byte5", base + 5);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("t5_rst_tx_valid", bus.tx_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_err_cnt", err_cnt, 0);
    chk("t5_rst_drop_cnt", drop_cnt, 0);
    chk("t5_rst_op_a", op_a, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // stall after 6 request bytes
    a = 64'h0000_0007_0000_0003;
    b = 64'h0000_0000_0000_0009;
    base  = opv_cnt;
    b_err = errp_cnt;
`ifdef RX_TIMEOUT_EN
    send_part(a, b, req_ck(a, b), 0, 6);
    repeat (60) @(posedge clk);
    #1;
    chk("t6_tmo_pulses", errp_cnt - b_err, 1);
    chk("t6_tmo_err_cnt", err_cnt, 1);
    chk("t6_tmo_no_op", opv_cnt - base, 0);
    push_resp(a + b);
    send_req(a, b, req_ck(a, b));
    wait_done("t6_after_tmo_done");
    chk("t6_after_tmo_op", opv_cnt - base, 1);
`else
    push_resp(a + b);
    send_part(a, b, req_ck(a, b), 0, 6);
    repeat (60) @(posedge clk);
    #1;
    chk("t6_stall_busy", busy, 0);
    send_part(a, b, req_ck(a, b), 6, 19);
    wait_done("t6_stall_done");
    chk("t6_stall_err_cnt", err_cnt, 0);
    chk("t6_stall_op_a", op_a, a);
    chk("t6_stall_op", opv_cnt - base, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("end_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_packet_sequencer.md
Name: add_packet_sequencer

Overview:
- Byte-level controller between the UART rx/tx byte interfaces and the four 64-bit adders.
- Parses the PC→FPGA request packet (header 0xBACD, operand A, operand B, checksum) and validates the checksum.
- Drives the shared adder operands, waits for the adders to settle, selects one of the four adder results by button choice, then serializes the FPGA→PC response packet (header 0xBAFD, result, checksum).

Parameters:
- ADD_LATENCY, 1, cycles from operand update to result capture (0–15).
- TIMEOUT_CYCLES, 100000, max idle cycles between request bytes (used only with RX_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- btn_l/btn_u/btn_r/btn_d  in  1 each  synchronized button levels; select adder 0/1/2/3
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready
- op_a, op_b  out  64 each  shared adder operands
- op_valid  out  1  one-cycle pulse when operands update
- res0..res3  in  64 each  adder results
- sel  out  2  current adder selection
- busy  out  1  high in WAIT or SEND
- err_pulse  out  1  one-cycle pulse on checksum mismatch or timeout abort
- err_cnt  out  8  saturating error count
- drop_cnt  out  8  saturating count of rx bytes ignored while busy

Behaviour:
- All multi-byte fields little-endian (LSB byte first).
- Request: 19 bytes = CD BA, A[7:0]..A[63:56], B[7:0]..B[63:56], CK.
  - CK = (0xBACD + A + B) mod 256, i.e. (0xCD + A[7:0] + B[7:0]) mod 256.
- Response: 11 bytes = FD BA, R[7:0]..R[63:56], CK2.
  - CK2 = (0xFD + R[7:0]) mod 256.
- Reset values: tx_data=0, tx_valid=0, op_a=op_b=0, op_valid=0, sel=0, busy=0, err_pulse=0, err_cnt=0, drop_cnt=0; state IDLE.
- sel: updated every cycle any button is high, priority l>u>r>d; holds otherwise. Sampled at result capture.
- FSM, with byte index counter:
  - IDLE: rx byte 0xCD → HDR1; any other byte ignored.
  - HDR1: 0xBA → OPA. 0xCD → stay HDR1 (resync). Other → IDLE.
  - OPA: 8 bytes into shadow A → OPB.
  - OPB: 8 bytes into shadow B → CSUM. The running checksum accumulator covers 0xCD and the LSB bytes.
  - CSUM:
    - Match: next cycle op_a/op_b ← shadows, op_valid=1, latency counter=ADD_LATENCY → WAIT.
    - Mismatch: err_pulse, err_cnt+1 → IDLE; op_a/op_b unchanged.
  - WAIT: counter decrements each cycle. When counter==0, capture res[sel] into response register, compute CK2 → SEND.
  - SEND: tx_valid=1 from the cycle after capture. A byte advances only on tx_valid&&tx_ready. The next byte is presented the following cycle, so tx_valid stays high across bytes. tx_data is stable while tx_ready is low. After byte 10 is accepted, tx_valid=0 → IDLE.
- Bytes are consumed only on rx_valid. rx_valid in WAIT/SEND: byte dropped, drop_cnt+1 (saturating at 255), no state effect.
- Timing, ADD_LATENCY=1: op_valid at T+1 after CK accepted at T; capture at T+2; first tx_valid at T+3.
- Reset asserted mid-packet or mid-SEND: immediate return to reset values next edge; a partial response is abandoned.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined:
  - In HDR1/OPA/OPB/CSUM, a counter reloads on each rx_valid.
  - If TIMEOUT_CYCLES cycles pass with no rx_valid: err_pulse, err_cnt+1 → IDLE; shadows discarded.
  - Counter inactive in IDLE/WAIT/SEND.
- Undefined: no timeout; the parser waits indefinitely for the next byte.

Test Plan:
- Good request, btn_l held, res0=A+B: send CD BA 0C 00×7 0D 00×7 E6 → op_a=12, op_b=13, one op_valid pulse. tx emits FD BA 19 00×7 16; err_cnt=0.
- Same operands, CK=E7 → err_pulse once, err_cnt=1, no op_valid, tx_valid never high; a following good packet is processed normally.
- Resync: CD CD BA + valid body/CK → accepted. CD 55 then valid packet → first discarded, second accepted.
- Backpressure: tx_ready low 5 cycles at byte 3 → tx_data held at byte 3 value, tx_valid held high; all 11 bytes delivered in order, none duplicated. btn_d with res3=0xFFFF_FFFF_FFFF_FFFF → response bytes FD BA FF×8 FC.
- Bytes sent during SEND → drop_cnt increments per byte, response unaffected. rst_n low during byte 5 of SEND → tx_valid=0 next cycle, all counters 0, IDLE.
- With RX_TIMEOUT_EN and TIMEOUT_CYCLES=50: stop after 6 bytes for 60 cycles → err_pulse, IDLE; the next full packet is accepted. Without the macro, the same stall followed by the remaining bytes yields a correct response.
